// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: idle-detect / wake-up controller for a clk_gate_p cell.
// Runs on the free-running clock; every output is a flop.
module clk_gate_ctrl #(
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              force_on,
  input  logic [IDLE_W-1:0] cfg_idle_thresh,
  input  logic              stat_clr,
  output logic              gate_en,
  output logic              wake_ack,
  output logic [1:0]        state,
  output logic [15:0]       off_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    IDLE = 2'd1,
    OFF  = 2'd2,
    WAKE = 2'd3
  } state_t;

  localparam int WCW =
    (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
  localparam logic [WCW-1:0] WAKE_LD = WCW'(WAKE_CYCLES);
  localparam state_t RST_ST =
    (WAKE_CYCLES == 0) ? RUN : WAKE;
  localparam logic RST_ACK = (WAKE_CYCLES == 0);

  state_t            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [WCW-1:0]    wake_q, wake_d;
  logic [15:0]       off_q, off_d;
  logic              gate_q, ack_q;
  logic              active;

  assign active = busy | wake_req | force_on;

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    wake_d  = wake_q;
    unique case (state_q)
      RUN: begin
        if (!active) begin
          if (cfg_idle_thresh == '0) begin
            state_d = OFF;
          end else begin
            state_d = IDLE;
            idle_d  = cfg_idle_thresh;
          end
        end
      end
      IDLE: begin
        if (active) begin
          state_d = RUN;
          idle_d  = '0;
        end else if (idle_q == IDLE_W'(1)) begin
          state_d = OFF;
          idle_d  = '0;
        end else begin
          idle_d = idle_q - IDLE_W'(1);
        end
      end
      OFF: begin
        if (active) begin
          if (WAKE_CYCLES == 0) begin
            state_d = RUN;
          end else begin
            state_d = WAKE;
            wake_d  = WAKE_LD;
          end
        end
      end
      WAKE: begin
        // wake runs to completion even if active drops
        if (wake_q <= WCW'(1)) begin
          state_d = RUN;
        end else begin
          wake_d = wake_q - WCW'(1);
        end
      end
      default: state_d = RST_ST;
    endcase
  end

  always_comb begin
    off_d = off_q;
    if (stat_clr) begin
      off_d = '0;
    end else if (state_q == OFF && off_q != 16'hFFFF) begin
      off_d = off_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_ST;
      idle_q  <= '0;
      wake_q  <= WAKE_LD;
      off_q   <= '0;
      gate_q  <= 1'b1;
      ack_q   <= RST_ACK;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      wake_q  <= wake_d;
      off_q   <= off_d;
      gate_q  <= (state_d != OFF);
      ack_q   <= (state_d == RUN) || (state_d == IDLE);
    end
  end

  assign gate_en  = gate_q;
  assign wake_ack = ack_q;
  assign state    = state_q;
  assign off_cnt  = off_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: table-driven bench with a scoreboard queue.
// Main DUT uses WAKE_CYCLES=2; a second instance covers WAKE_CYCLES=0.
module tb_clk_gate_ctrl;

  typedef struct {
    logic        rst_n;
    logic        busy;
    logic        wake_req;
    logic        force_on;
    logic        stat_clr;
    logic [7:0]  thr;
    logic [1:0]  st;
    logic [15:0] off;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic        wake_req;
  logic        force_on;
  logic        stat_clr;
  logic [7:0]  thr;
  logic        g2, a2, g0, a0;
  logic [1:0]  st2, st0;
  logic [15:0] off2, off0;

  int n_chk;
  int n_fail;
  vec_t sb[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  clk_gate_ctrl #(.IDLE_W(8), .WAKE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .busy(busy),
    .wake_req(wake_req), .force_on(force_on),
    .cfg_idle_thresh(thr), .stat_clr(stat_clr),
    .gate_en(g2), .wake_ack(a2), .state(st2),
    .off_cnt(off2)
  );

  clk_gate_ctrl #(.IDLE_W(8), .WAKE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .busy(busy),
    .wake_req(wake_req), .force_on(force_on),
    .cfg_idle_thresh(thr), .stat_clr(stat_clr),
    .gate_en(g0), .wake_ack(a0), .state(st0),
    .off_cnt(off0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rn, input logic b, input logic w,
    input logic f, input logic c, input logic [7:0] t,
    input logic [1:0] s, input logic [15:0] o);
    vec_t v;
    v.rst_n = rn; v.busy = b; v.wake_req = w;
    v.force_on = f; v.stat_clr = c; v.thr = t;
    v.st = s; v.off = o;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  task automatic cyc(input vec_t v, input bit do_chk,
                     input string tag);
    vec_t e;
    @(negedge clk);
    rst_n    = v.rst_n;
    busy     = v.busy;
    wake_req = v.wake_req;
    force_on = v.force_on;
    stat_clr = v.stat_clr;
    thr      = v.thr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (do_chk) begin
      chk({tag, ".state"}, 16'(st2), 16'(e.st));
      chk({tag, ".gate_en"}, 16'(g2), 16'(e.st != 2'd2));
      chk({tag, ".wake_ack"}, 16'(a2), 16'(e.st < 2'd2));
      chk({tag, ".off_cnt"}, off2, e.off);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0; busy = 1'b1; wake_req = 1'b0;
    force_on = 1'b0; stat_clr = 1'b0; thr = 8'd4;

    // reset held 3 cycles, then release: RUN two edges later
    for (int i = 0; i < 3; i++)
      tbl_a.push_back(mk(0,1,0,0,0,8'd4,2'd3,16'd0));
    tbl_a.push_back(mk(1,1,0,0,0,8'd4,2'd3,16'd0));
    tbl_a.push_back(mk(1,1,0,0,0,8'd4,2'd0,16'd0));
    tbl_a.push_back(mk(1,1,0,0,0,8'd4,2'd0,16'd0));
    // idle gating T=4; threshold changed mid-count is ignored
    tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd1,16'd0));
    for (int i = 0; i < 3; i++)
      tbl_a.push_back(mk(1,0,0,0,0,8'd200,2'd1,16'd0));
    tbl_a.push_back(mk(1,0,0,0,0,8'd200,2'd2,16'd0));
    for (int i = 1; i <= 10; i++)
      tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd2,16'(i)));
    // stat_clr during OFF, then counting resumes
    tbl_a.push_back(mk(1,0,0,0,1,8'd4,2'd2,16'd0));
    tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd2,16'd1));
    tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd2,16'd2));
    // single-cycle wake_req completes the wake
    tbl_a.push_back(mk(1,0,1,0,0,8'd4,2'd3,16'd3));
    tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd3,16'd3));
    tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd0,16'd3));
    tbl_a.push_back(mk(1,1,0,0,0,8'd4,2'd0,16'd3));
    // idle abort on the final idle cycle
    for (int i = 0; i < 4; i++)
      tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd1,16'd3));
    tbl_a.push_back(mk(1,1,0,0,0,8'd4,2'd0,16'd3));
    for (int i = 0; i < 4; i++)
      tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd1,16'd3));
    tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd2,16'd3));
    tbl_a.push_back(mk(1,0,0,0,0,8'd4,2'd2,16'd4));
    tbl_a.push_back(mk(1,1,0,0,0,8'd4,2'd3,16'd5));
    tbl_a.push_back(mk(1,1,0,0,0,8'd4,2'd3,16'd5));
    tbl_a.push_back(mk(1,1,0,0,0,8'd4,2'd0,16'd5));
    // T=0 gates on the next edge; reset mid-OFF
    tbl_b.push_back(mk(1,0,0,0,0,8'd0,2'd2,16'd5));
    tbl_b.push_back(mk(1,0,0,0,0,8'd0,2'd2,16'd6));
    tbl_b.push_back(mk(0,0,0,0,0,8'd0,2'd3,16'd0));
    tbl_b.push_back(mk(1,1,0,0,0,8'd0,2'd3,16'd0));
    tbl_b.push_back(mk(1,1,0,0,0,8'd0,2'd0,16'd0));

    foreach (tbl_a[i]) cyc(tbl_a[i], 1, $sformatf("a%0d", i));

    for (int i = 0; i < 300; i++)
      cyc(mk(1,0,0,1,0,8'd4,2'd0,16'd5), 1,
          $sformatf("force%0d", i));

    foreach (tbl_b[i]) cyc(tbl_b[i], 1, $sformatf("b%0d", i));

    // WAKE_CYCLES=0 instance: reset state RUN, ack one edge after wake
    cyc(mk(0,0,0,0,0,8'd0,2'd3,16'd0), 1, "w0_rst");
    chk("w0_rst.state", 16'(st0), 16'd0);
    chk("w0_rst.wake_ack", 16'(a0), 16'd1);
    cyc(mk(1,0,0,0,0,8'd0,2'd3,16'd0), 1, "w0_off");
    chk("w0_off.state", 16'(st0), 16'd2);
    chk("w0_off.gate_en", 16'(g0), 16'd0);
    chk("w0_off.wake_ack", 16'(a0), 16'd0);
    cyc(mk(1,0,1,0,0,8'd0,2'd0,16'd0), 1, "w0_wake");
    chk("w0_wake.state", 16'(st0), 16'd0);
    chk("w0_wake.gate_en", 16'(g0), 16'd1);
    chk("w0_wake.wake_ack", 16'(a0), 16'd1);
    cyc(mk(1,0,0,0,0,8'd0,2'd2,16'd0), 1, "w0_regate");
    chk("w0_regate.state", 16'(st0), 16'd2);

    // off_cnt saturation
    cyc(mk(1,0,0,0,1,8'd0,2'd2,16'd0), 1, "sat_clr");
    for (int i = 1; i <= 65534; i++)
      cyc(mk(1,0,0,0,0,8'd0,2'd2,16'(i)), 0, "sat_run");
    chk("sat_fffe", off2, 16'hFFFE);
    for (int i = 0; i < 3; i++)
      cyc(mk(1,0,0,0,0,8'd0,2'd2,16'hFFFF), 1,
          $sformatf("sat%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
